// File: rtl/tb_mem_dump.sv
// Memory read-back engine: walks a word range and streams it as readmem-style hex text.
// Define TB_MEM_DUMP_ADDR_PREFIX_EN to prepend an "@<base>" header line to each dump.
module tb_mem_dump #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [63:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
        S_HDR,
`endif
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
    localparam int HEX_N = (ADDR_W + 3) / 4;
    localparam int HDR_W = 4 * HEX_N;
    logic [HDR_W-1:0] hdr_q;
`endif

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              req_q;
    logic              valid_q;
    logic [7:0]        data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [63:0]       sh_q;
    logic [4:0]        cnt_q;
    logic              hs;
    logic [7:0]        byte_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign hs = valid_q && out_ready;

    // cnt_q is the index of the byte currently on out_data; byte 16 is the newline
    always_comb begin
        byte_d = hex_char(sh_q[59:56]);
        if (cnt_q == 5'd15) begin
            byte_d = 8'h0a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
            hdr_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            addr_q <= base_addr;
                            rem_q  <= num_words;
                            busy_q <= 1'b1;
`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
                            hdr_q   <= HDR_W'(base_addr);
                            cnt_q   <= '0;
                            valid_q <= 1'b1;
                            data_q  <= 8'h40;
                            state_q <= S_HDR;
`else
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
`endif
                        end
                    end
                end
`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
                S_HDR: begin
                    if (hs) begin
                        if (cnt_q == 5'(HEX_N + 1)) begin
                            valid_q <= 1'b0;
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                            if (cnt_q == 5'(HEX_N)) begin
                                data_q <= 8'h0a;
                            end else begin
                                data_q <= hex_char(hdr_q[HDR_W-1 -: 4]);
                                hdr_q  <= hdr_q << 4;
                            end
                        end
                    end
                end
`endif
                S_REQ: begin
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        addr_q  <= addr_q + ADDR_W'(1);
                        rem_q   <= rem_q - (ADDR_W + 1)'(1);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        sh_q    <= mem_rdata;
                        data_q  <= hex_char(mem_rdata[63:60]);
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (hs) begin
                        if (cnt_q == 5'd16) begin
                            valid_q <= 1'b0;
                            if (rem_q != '0) begin
                                req_q   <= 1'b1;
                                state_q <= S_REQ;
                            end else begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end
                        end else begin
                            cnt_q  <= cnt_q + 5'd1;
                            data_q <= byte_d;
                            sh_q   <= sh_q << 4;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_tb_mem_dump.sv
// Scoreboard bench for tb_mem_dump: random memory timing and sink backpressure,
// expected text built from memory contents with $sformatf.
module tb_tb_mem_dump;

    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [63:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;

    logic [63:0] mem [0:4095];
    logic [7:0]  exp_q[$];
    int          exp_addr_q[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   hs_total = 0;
    int   done_total = 0;
    int   last_hs_cyc = 0;
    int   amax = 0;
    int   rmin = 1;
    int   rmax = 1;
    int   rdy_pct = 100;
    logic rdy_rand = 1'b1;
    logic rdy_en = 1'b1;
    logic inject_rv = 1'b0;
    logic rv_model = 1'b0;

    assign out_ready  = rdy_rand & rdy_en;
    assign mem_rvalid = rv_model | inject_rv;

    tb_mem_dump #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sink readiness, changed just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rdy_rand = ($urandom_range(99, 0) < rdy_pct);
        end
    end

    // Memory port responder: random ack / rvalid latency, checks request addresses
    initial begin
        int ack_cnt;
        int rv_cnt;
        bit rv_pend;
        bit last_req;
        bit last_ack;
        logic [AW-1:0] last_addr;
        logic [63:0] rv_dat;
        int a;
        ack_cnt = 0; rv_cnt = 0; rv_pend = 0;
        last_req = 0; last_ack = 0; last_addr = '0; rv_dat = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            rv_model = 1'b0;
            if (reset) begin
                rv_pend = 0; last_req = 0; last_ack = 0;
            end else begin
                if (last_req && !last_ack) begin
                    check("req_held", mem_req, 1);
                    check("addr_stable", mem_addr, last_addr);
                end
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        rv_model = 1'b1;
                        mem_rdata = rv_dat;
                        rv_pend = 0;
                    end else rv_cnt--;
                end
                if (mem_req) begin
                    if (ack_cnt == 0) begin
                        mem_ack = 1'b1;
                        if (exp_addr_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_req: addr %0h, none expected", mem_addr);
                        end else begin
                            a = exp_addr_q.pop_front();
                            check("req_addr", mem_addr, a);
                        end
                        rv_pend = 1;
                        rv_cnt = $urandom_range(rmax, rmin) - 1;
                        rv_dat = mem[mem_addr];
                        ack_cnt = $urandom_range(amax, 0);
                    end else ack_cnt--;
                end
                last_req = mem_req;
                last_ack = mem_ack;
                last_addr = mem_addr;
            end
        end
    end

    // Output monitor: pops the scoreboard on every byte handshake
    initial begin
        bit pv;
        bit pr;
        bit pdone;
        logic [7:0] pd;
        logic [7:0] e;
        pv = 0; pr = 0; pdone = 0; pd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0; pdone = 0;
            end else begin
                if (pv && !pr) begin
                    check("valid_held", out_valid, 1);
                    check("data_stable", out_data, pd);
                end
                if (out_valid && out_ready) begin
                    hs_total++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_byte: got %02h, none expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", out_data, e);
                    end
                end
                if (done) begin
                    done_total++;
                    check("done_busy_low", busy, 0);
                    check("done_single", pdone, 0);
                end
                pv = out_valid; pr = out_ready; pd = out_data; pdone = done;
            end
        end
    end

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    endtask

    task automatic push_dump(input logic [AW-1:0] b, input int n);
        int a;
`ifdef TB_MEM_DUMP_ADDR_PREFIX_EN
        if (n > 0) push_str($sformatf("@%03h\n", b));
`endif
        for (int i = 0; i < n; i++) begin
            a = (int'(b) + i) % 4096;
            exp_addr_q.push_back(a);
            push_str($sformatf("%016h\n", mem[a]));
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, output int s);
        @(posedge clk);
        #1;
        base_addr = b;
        num_words = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            n_chk++;
            $display("FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        int s;
        int dc;
        int h0;
        int d0;
        int nb;
        logic [AW-1:0] b;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 reset = 1'b0;

        // Known pattern, earliest handshakes
        mem[0] = 64'h0123456789abcdef;
        mem[1] = 64'h0;
        mem[2] = 64'hffffffffffffffff;
        exp_addr_q.push_back(0);
        exp_addr_q.push_back(1);
        exp_addr_q.push_back(2);
        push_str("0123456789abcdef\n0000000000000000\nffffffffffffffff\n");
        h0 = hs_total;
        do_start(12'h000, 13'd3, s);
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_req", mem_req, 1);
        wait_done(400, dc);
`ifndef TB_MEM_DUMP_ADDR_PREFIX_EN
        check("t1_done_cycle", dc, s + 57);
`endif
        check("t1_done_after_last", dc, last_hs_cyc + 1);
        check("t1_bytes", hs_total - h0, 51);
        check("t1_drained", exp_q.size(), 0);

        // Same data under backpressure and slow memory
        rdy_pct = 30; amax = 5; rmin = 1; rmax = 7;
        push_dump(12'h000, 3);
        h0 = hs_total;
        do_start(12'h000, 13'd3, s);
        wait_done(4000, dc);
        check("t2_done_after_last", dc, last_hs_cyc + 1);
        check("t2_bytes", hs_total - h0, 51);
        check("t2_drained", exp_q.size() + exp_addr_q.size(), 0);

        // Address wrap
        mem[4095] = {$urandom, $urandom};
        mem[0] = {$urandom, $urandom};
        push_dump(12'hfff, 2);
        h0 = hs_total;
        do_start(12'hfff, 13'd2, s);
        wait_done(4000, dc);
        check("t3_bytes", hs_total - h0, 34);
        check("t3_drained", exp_q.size() + exp_addr_q.size(), 0);

        // Zero-length dump
        rdy_pct = 100; amax = 2; rmin = 1; rmax = 3;
        h0 = hs_total;
        do_start(AW'($urandom), 13'd0, s);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_done", done, (i == 0));
            check("zero_quiet", {busy, mem_req, out_valid}, 0);
        end
        check("zero_bytes", hs_total - h0, 0);

        // Start pulses while busy are ignored
        b = AW'($urandom);
        push_dump(b, 4);
        h0 = hs_total;
        d0 = done_total;
        do_start(b, 13'd4, s);
        for (int p = 0; p < 2; p++) begin
            repeat (15 + 20 * p) @(posedge clk);
            #1;
            base_addr = AW'($urandom);
            num_words = 13'd2;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(4000, dc);
        repeat (60) @(negedge clk);
        check("t5_bytes", hs_total - h0, 68);
        check("t5_one_done", done_total - d0, 1);
        check("t5_drained", exp_q.size() + exp_addr_q.size(), 0);

        // Reset mid-line, then a spurious rvalid
        amax = 0; rmin = 1; rmax = 1;
        b = AW'($urandom);
        push_dump(b, 2);
        do_start(b, 13'd2, s);
        nb = 0;
        for (int i = 0; i < 500 && nb < 5; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) nb++;
        end
        check("t6_reached_5", nb, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rdy_en = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        inject_rv = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        inject_rv = 1'b0;
        rdy_en = 1'b1;
        h0 = hs_total;
        d0 = done_total;
        repeat (30) @(negedge clk);
        check("t6_no_bytes", hs_total - h0, 0);
        check("t6_no_done", done_total - d0, 0);
        check("t6_quiet", {busy, mem_req, out_valid}, 0);

        // Fresh dump after reset
        b = AW'($urandom);
        push_dump(b, 1);
        h0 = hs_total;
        do_start(b, 13'd1, s);
        wait_done(400, dc);
        check("t7_bytes", hs_total - h0, 17);
        check("t7_drained", exp_q.size() + exp_addr_q.size(), 0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
